mul_hash_combine: RTL and testbench
===================================

# mul_hash_combine

Consumer side of the multiplicative hash in the Pigasus SME front end. It issues 16-bit windows to the multiplicative hash source, tracks each accepted window through the source's fixed latency, and sums the returned 16-bit-shifted partial products into the 64-bit product mod 2^64. It then extracts the top HASH_W bits as the hash-table index and buffers results in an output FIFO. Credit-based issue guarantees the FIFO never overflows under output backpressure.

## Interface
- DSP_LAT, 3: latency of one DSP multiplier instance; source latency SRC_LAT = DSP_LAT+2.
- HASH_W, 12: hash width, 1..32.
- TAG_W, 16: sideband tag width.
- FIFO_DEPTH, 16: output FIFO depth; power of 2, ≥ SRC_LAT+3.

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  window request; upstream drives the source's `a` in the same cycle
- in_ready  out  1  credit available; reset 0
- in_sel  in  2  00 full, 01 full 1's-complement, 10 masked, 11 masked 1's-complement
- in_tag  in  TAG_W  carried to output
- pp_full  in  128  {ab3,ab2,ab1,ab0}, 32 b each
- pp_full_1sc  in  128  {ab3,ab2,ab1,ab0} of ~a
- pp_msk  in  96  {ab3,ab2,ab1,ab0}, 24 b each, a[15:8] terms
- pp_msk_1sc  in  96  masked terms of ~a
- out_valid  out  1  FIFO non-empty; reset 0
- out_ready  in  1  consumer accept
- out_hash  out  HASH_W  hash index; reset 0
- out_tag  out  TAG_W  reset 0
- out_sel  out  2  reset 0

## Operation
- Accept at cycle t when in_valid & in_ready. {1, sel, tag} enters an SRC_LAT-deep delay line. At t+SRC_LAT, the 4 terms of the selected group are captured (masked terms zero-extended to 32 b).
- Stage 1 (t+SRC_LAT+1): lo = ab0 + (ab1<<16), 48 b; hi = ab2 + (ab3<<16), 32 b truncated.
- Stage 2 (t+SRC_LAT+2): s = (lo + (hi<<32)) mod 2^64; hash = s[63:64-HASH_W]. {hash, tag, sel} is written to the FIFO.
- All additions are unsigned and wrap mod 2^64. No saturation.
- inflight counts accepted entries not yet written: +1 on accept, −1 on FIFO write, both in the same cycle ⇒ no change. Range 0..SRC_LAT+2.
- in_ready = rst released & (fifo_count + inflight < FIFO_DEPTH). This is a registered-free combinational function of counters, not of in_valid.
- The FIFO is first-word fall-through. A pop occurs on out_valid & out_ready. Simultaneous push and pop leaves the count unchanged. Push when full is impossible by construction; if it occurs anyway, the debug assertion fires and the entry is dropped.
- FIFO pointers wrap at FIFO_DEPTH. The count is (log2 FIFO_DEPTH)+1 bits.
- Order preserved: output order == accept order.

## Timing
- Accept to out_valid: SRC_LAT+3 cycles when the FIFO is empty and the consumer is idle (8 for defaults).
- Sustained throughput 1 window/cycle while out_ready is held 1.
- With out_ready=0: exactly FIFO_DEPTH accepts occur, then in_ready stays 0 until a pop. After the pop, in_ready returns 1 in the same cycle the count drops.
- Reset assert (any cycle): delay line valids, stage valids, inflight, FIFO pointers/count, and all outputs clear asynchronously. Products arriving after reset are ignored.
- in_ready rises on the first clk edge after rst_n deasserts.

## Configuration
- MUL_HASH_COMBINE_MSK_EN defined: in_sel[1] selects the masked groups as above.
- Not defined: in_sel[1] is ignored (treated as 0), and pp_msk/pp_msk_1sc are unused. out_sel[1] is always 0.

## Test plan
B = 0x0b4e0ef37bc32127. The bench source model computes the partial products of a·B.
- Reset/idle: rst_n=0 → all outputs 0, in_ready 0. First edge after release → in_ready 1.
- a=0x0001, sel=00, tag=0x55 → at t+8: out_hash=0x0b4, out_tag=0x55.
- a=0x0000, sel=01 (product 0x03A56CCFA563DED9) → out_hash=0x03A. Same stimulus with sel=00 → out_hash=0x000.
- a=0x0100, sel=10 (macro defined) → out_hash=0x0b4. Without the macro, sel=10 gives out_hash=B·0x0100 top 12 = 0x4e0 and out_sel=00.
- out_ready=0 with in_valid held 1 → exactly 16 accepts. in_ready is 0 thereafter with no loss. Release out_ready → 16 hashes in tag order, then issue resumes.
- Back-to-back 1000 random windows, random out_ready → every hash matches the model and tags are in order. An rst_n pulse mid-stream → out_valid 0 immediately, and no stale entries appear afterward.

Source files
------------

// File: rtl/mul_hash_combine_if.sv
// Handshake and partial-product bundle between the multiplicative hash
// source, the combine stage and the hash-index consumer.
// master: upstream/consumer side; slave: the combine stage.
interface mul_hash_combine_if #(
  parameter int HASH_W = 12,
  parameter int TAG_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_sel;
  logic [TAG_W-1:0]  in_tag;
  logic [127:0]      pp_full;
  logic [127:0]      pp_full_1sc;
  logic [95:0]       pp_msk;
  logic [95:0]       pp_msk_1sc;
  logic              out_valid;
  logic              out_ready;
  logic [HASH_W-1:0] out_hash;
  logic [TAG_W-1:0]  out_tag;
  logic [1:0]        out_sel;

  modport master (
    output in_valid, in_sel, in_tag,
    output pp_full, pp_full_1sc,
    output pp_msk, pp_msk_1sc,
    output out_ready,
    input  in_ready, out_valid,
    input  out_hash, out_tag, out_sel
  );

  modport slave (
    input  in_valid, in_sel, in_tag,
    input  pp_full, pp_full_1sc,
    input  pp_msk, pp_msk_1sc,
    input  out_ready,
    output in_ready, out_valid,
    output out_hash, out_tag, out_sel
  );
endinterface

// File: rtl/mul_hash_combine.sv
// mul_hash_combine: sums shifted partial products into a*B mod 2^64,
// takes the top HASH_W bits as hash index and buffers them in a FWFT FIFO.
// Ports: clk, rst_n (async active-low), bus (mul_hash_combine_if.slave):
//   in_valid/in_ready/in_sel/in_tag request side, pp_* source products,
//   out_valid/out_ready/out_hash/out_tag/out_sel result side.
// Macro MUL_HASH_COMBINE_MSK_EN enables the masked (a[15:8]) groups.
module mul_hash_combine #(
  parameter int DSP_LAT    = 3,
  parameter int HASH_W     = 12,
  parameter int TAG_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  mul_hash_combine_if.slave bus
);
  localparam int SRC_LAT = DSP_LAT + 2;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int IW      = $clog2(SRC_LAT + 3);
  localparam int EW      = HASH_W + TAG_W + 2;

  logic             w_acc;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic [1:0]       w_sel;
  logic [1:0]       w_dsel;
  logic [3:0][31:0] w_ab;
  logic [47:0]      w_lo;
  logic [31:0]      w_hi;
  logic [63:0]      w_s;
  logic [EW-1:0]    w_wdat;
  logic [EW-1:0]    w_rdat;

  logic               r_run;
  logic [SRC_LAT-1:0] r_dl_v;
  logic [1:0]         r_dl_sel [SRC_LAT];
  logic [TAG_W-1:0]   r_dl_tag [SRC_LAT];
  logic               r_c_v;
  logic [1:0]         r_c_sel;
  logic [TAG_W-1:0]   r_c_tag;
  logic [3:0][31:0]   r_ab;
  logic               r_1_v;
  logic [1:0]         r_1_sel;
  logic [TAG_W-1:0]   r_1_tag;
  logic [47:0]        r_lo;
  logic [31:0]        r_hi;
  logic [IW-1:0]      r_infl;
  logic [AW-1:0]      r_wp;
  logic [AW-1:0]      r_rp;
  logic [CW-1:0]      r_cnt;
  logic [EW-1:0]      r_mem [FIFO_DEPTH];

`ifdef MUL_HASH_COMBINE_MSK_EN
  assign w_sel = bus.in_sel;
`else
  assign w_sel = {1'b0, bus.in_sel[0]};
`endif

  assign w_acc  = bus.in_valid & bus.in_ready;
  assign w_dsel = r_dl_sel[SRC_LAT-1];

  // Reserve FIFO room for everything still in flight so a
  // stalled consumer can never overflow the FIFO.
  assign bus.in_ready = r_run &
    ((32'(r_cnt) + 32'(r_infl)) < 32'(FIFO_DEPTH));

  always_comb begin
    w_ab = w_dsel[0] ? bus.pp_full_1sc : bus.pp_full;
`ifdef MUL_HASH_COMBINE_MSK_EN
    if (w_dsel[1]) begin
      for (int k = 0; k < 4; k++) begin
        w_ab[k] = w_dsel[0] ?
          {8'd0, bus.pp_msk_1sc[24*k +: 24]} :
          {8'd0, bus.pp_msk[24*k +: 24]};
      end
    end
`endif
  end

  assign w_lo = {16'd0, r_ab[0]} + {r_ab[1], 16'd0};
  // ab3 bits above 15 land beyond bit 63 of the product.
  assign w_hi = r_ab[2] + {r_ab[3][15:0], 16'd0};
  assign w_s  = {16'd0, r_lo} + {r_hi, 32'd0};

  assign w_wdat = {w_s[63 -: HASH_W], r_1_tag, r_1_sel};
  assign w_full = (r_cnt == CW'(FIFO_DEPTH));
  assign w_push = r_1_v & ~w_full;
  assign w_pop  = bus.out_valid & bus.out_ready;

  assign bus.out_valid = (r_cnt != '0);
  assign w_rdat   = bus.out_valid ? r_mem[r_rp] : '0;
  assign bus.out_hash = w_rdat[EW-1 -: HASH_W];
  assign bus.out_tag  = w_rdat[TAG_W+1:2];
  assign bus.out_sel  = w_rdat[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run   <= 1'b0;
      r_dl_v  <= '0;
      for (int k = 0; k < SRC_LAT; k++) begin
        r_dl_sel[k] <= '0;
        r_dl_tag[k] <= '0;
      end
      r_c_v   <= 1'b0;
      r_c_sel <= '0;
      r_c_tag <= '0;
      r_ab    <= '0;
      r_1_v   <= 1'b0;
      r_1_sel <= '0;
      r_1_tag <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_infl  <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
    end else begin
      r_run       <= 1'b1;
      r_dl_v[0]   <= w_acc;
      r_dl_sel[0] <= w_sel;
      r_dl_tag[0] <= bus.in_tag;
      for (int k = 1; k < SRC_LAT; k++) begin
        r_dl_v[k]   <= r_dl_v[k-1];
        r_dl_sel[k] <= r_dl_sel[k-1];
        r_dl_tag[k] <= r_dl_tag[k-1];
      end
      r_c_v   <= r_dl_v[SRC_LAT-1];
      r_c_sel <= w_dsel;
      r_c_tag <= r_dl_tag[SRC_LAT-1];
      if (r_dl_v[SRC_LAT-1]) r_ab <= w_ab;
      r_1_v   <= r_c_v;
      r_1_sel <= r_c_sel;
      r_1_tag <= r_c_tag;
      if (r_c_v) begin
        r_lo <= w_lo;
        r_hi <= w_hi;
      end
      unique case ({w_acc, r_1_v})
        2'b10:   r_infl <= r_infl + IW'(1);
        2'b01:   r_infl <= r_infl - IW'(1);
        default: ;
      endcase
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= w_wdat;
  end

  a_no_ovf: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(r_1_v && w_full));

endmodule

// File: tb/tb_mul_hash_combine.sv
// Bench for mul_hash_combine: source model feeds partial products of a*B,
// scoreboard queue checks hash/tag/sel order against a direct multiply.
`timescale 1ns/1ps
module tb_mul_hash_combine;
  localparam int DSP_LAT = 3;
  localparam int SRC_LAT = DSP_LAT + 2;
  localparam int HASH_W  = 12;
  localparam int TAG_W   = 16;
  localparam int DEPTH   = 16;
  localparam logic [63:0] B = 64'h0b4e0ef37bc32127;

  typedef struct packed {
    logic [HASH_W-1:0] h;
    logic [TAG_W-1:0]  t;
    logic [1:0]        s;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] a_pipe [SRC_LAT];
  logic [TAG_W-1:0] tag_next = '0;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int n_acc = 0;

  always #5 clk = ~clk;

  mul_hash_combine_if #(.HASH_W(HASH_W), .TAG_W(TAG_W)) bus ();

  mul_hash_combine #(
    .DSP_LAT(DSP_LAT), .HASH_W(HASH_W),
    .TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  function automatic logic [127:0] pp_of(input logic [15:0] x);
    logic [63:0] b;
    b = B;
    pp_of = '0;
    for (int k = 0; k < 4; k++)
      pp_of[32*k +: 32] = 32'(x) * 32'(b[16*k +: 16]);
  endfunction

  function automatic logic [95:0] pm_of(input logic [15:0] x);
    logic [63:0] b;
    b = B;
    pm_of = '0;
    for (int k = 0; k < 4; k++)
      pm_of[24*k +: 24] = 24'(x[15:8]) * 24'(b[16*k +: 16]);
  endfunction

  function automatic logic [HASH_W-1:0] hash_of(
    input logic [15:0] x, input logic [1:0] s);
    logic [63:0] p;
    logic [63:0] b;
    logic [15:0] y;
    b = B;
    y = s[0] ? ~x : x;
`ifdef MUL_HASH_COMBINE_MSK_EN
    if (s[1]) y = {8'h00, y[15:8]};
`endif
    p = 64'(y) * b;
    return p[63 -: HASH_W];
  endfunction

  function automatic logic [1:0] sel_of(input logic [1:0] s);
`ifdef MUL_HASH_COMBINE_MSK_EN
    return s;
`else
    return {1'b0, s[0]};
`endif
  endfunction

  always @(posedge clk) begin
    a_pipe[0] <= a;
    for (int k = 1; k < SRC_LAT; k++) a_pipe[k] <= a_pipe[k-1];
  end

  assign bus.pp_full     = pp_of(a_pipe[SRC_LAT-1]);
  assign bus.pp_full_1sc = pp_of(~a_pipe[SRC_LAT-1]);
  assign bus.pp_msk      = pm_of(a_pipe[SRC_LAT-1]);
  assign bus.pp_msk_1sc  = pm_of(~a_pipe[SRC_LAT-1]);

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // Push accepts, pop/compare results; called once per cycle.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (bus.in_valid && bus.in_ready) begin
      e.h = hash_of(a, bus.in_sel);
      e.t = bus.in_tag;
      e.s = sel_of(bus.in_sel);
      q.push_back(e);
      n_acc++;
      tag_next++;
    end
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("extra_out", 64'(bus.out_valid), 0);
      end else begin
        e = q.pop_front();
        chk("sb_hash", 64'(bus.out_hash), 64'(e.h));
        chk("sb_tag", 64'(bus.out_tag), 64'(e.t));
        chk("sb_sel", 64'(bus.out_sel), 64'(e.s));
      end
    end
  endtask

  task automatic one(input logic [15:0] x, input logic [1:0] s,
                     input logic [TAG_W-1:0] t,
                     input logic [HASH_W-1:0] eh,
                     input logic [1:0] es);
    int lat;
    bit got;
    @(posedge clk);
    #1;
    a = x;
    bus.in_sel = s;
    bus.in_tag = t;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("one_rdy", 64'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) got = 1'b1;
    end
    chk("one_lat", 64'(lat), 8);
    chk("one_hash", 64'(bus.out_hash), 64'(eh));
    chk("one_tag", 64'(bus.out_tag), 64'(t));
    chk("one_sel", 64'(bus.out_sel), 64'(es));
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bus.in_valid = 1'b0;
    bus.in_sel = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 0);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_out_hash", 64'(bus.out_hash), 0);
    chk("rst_out_tag", 64'(bus.out_tag), 0);
    chk("rst_out_sel", 64'(bus.out_sel), 0);
    rst_n = 1'b1;
    #1;
    chk("rel_rdy_pre", 64'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    chk("rel_rdy_post", 64'(bus.in_ready), 1);

    one(16'h0001, 2'b00, 16'h0055, 12'h0b4, 2'b00);
    one(16'h0000, 2'b01, 16'h0011, 12'h03a, 2'b01);
    one(16'h0000, 2'b00, 16'h0022, 12'h000, 2'b00);
`ifdef MUL_HASH_COMBINE_MSK_EN
    one(16'h0100, 2'b10, 16'h0033, 12'h0b4, 2'b10);
`else
    one(16'h0100, 2'b10, 16'h0033, 12'h4e0, 2'b00);
`endif
    one(16'h0100, 2'b11, 16'h0044,
        hash_of(16'h0100, 2'b11), sel_of(2'b11));

    // Backpressure: consumer stalled, requests held.
    @(posedge clk);
    #1;
    n_acc = 0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      bus.in_sel = 2'($urandom);
      bus.in_tag = tag_next;
      sample();
      @(posedge clk);
      #1;
    end
    chk("bp_accepts", 64'(n_acc), 16);
    chk("bp_rdy_full", 64'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    sample();
    chk("bp_rdy_pre_pop", 64'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    chk("bp_rdy_post_pop", 64'(bus.in_ready), 1);
    for (int i = 0; i < 40 && q.size() > 0; i++) begin
      sample();
      @(posedge clk);
      #1;
    end
    chk("bp_drained", 64'(q.size()), 0);

    // Random stream with a mid-stream reset pulse.
    n_acc = 0;
    cyc = 0;
    while (n_acc < 1000 && cyc < 8000) begin
      bus.in_valid = ($urandom_range(3) != 0);
      a = 16'($urandom);
      bus.in_sel = 2'($urandom);
      bus.in_tag = tag_next;
      bus.out_ready = ($urandom_range(2) != 0);
      if (cyc == 600) begin
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", 64'(bus.out_valid), 0);
        chk("mid_rst_rdy", 64'(bus.in_ready), 0);
        chk("mid_rst_hash", 64'(bus.out_hash), 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        sample();
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("rnd_accepts", 64'(n_acc >= 1000), 1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100 && (q.size() > 0 || bus.out_valid); i++) begin
      sample();
      @(posedge clk);
      #1;
    end
    chk("rnd_drained", 64'(q.size()), 0);
    chk("end_out_valid", 64'(bus.out_valid), 0);
    chk("end_in_ready", 64'(bus.in_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
